// File: rtl/pixel_stream_unpacker_pkg.sv
// pixel_stream_unpacker_pkg: shared video geometry, phase/pixel types and byte-lane to RGB mapping
package pixel_stream_unpacker_pkg;
  localparam int X_SIZE_DEF = 640;
  localparam int Y_SIZE_DEF = 480;
  localparam int XW = 10;
  localparam int YW = 9;
  typedef enum logic [1:0] {PH0, PH1, PH2} phase_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  function automatic int words_per_line(input int xs);
    return xs * 3 / 4;
  endfunction
  function automatic rgb_t lanes_to_rgb(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    return {b2, b1, b0};
  endfunction
endpackage

// File: rtl/pixel_stream_unpacker_pixel_pos_counter.sv
// pixel_pos_counter: x/y pixel position with line/frame wrap, stepping 1 or 2 pixels, frame restart and forced new line
module pixel_pos_counter
  import pixel_stream_unpacker_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int Y_SIZE = Y_SIZE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          frm,
  input  logic          nl,
  input  logic [1:0]    adv,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [XW-1:0] bx,
  output logic [YW-1:0] by,
  output logic          sof,
  output logic          eol
);
  logic [XW:0]   nx;
  logic [YW-1:0] ny;
  logic          wrap;
  assign bx   = frm ? '0 : x;
  assign by   = frm ? '0 : y;
  assign sof  = bx == '0 && by == '0;
  assign eol  = bx == XW'(X_SIZE - 1);
  assign nx   = {1'b0, bx} + (XW + 1)'(adv);
  assign wrap = nl || nx >= (XW + 1)'(X_SIZE);
  assign ny   = by == YW'(Y_SIZE - 1) ? '0 : by + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      x <= wrap ? '0 : nx[XW-1:0];
      y <= wrap ? ny : by;
    end
  end
endmodule

// File: rtl/pixel_stream_unpacker.sv
// pixel_stream_unpacker: unpacks 4-pixels-per-3-words RGB AXI4-Stream into x/y tagged pixels with framing checks
module pixel_stream_unpacker
  import pixel_stream_unpacker_pkg::*;
#(
  parameter int X_SIZE    = X_SIZE_DEF,
  parameter int Y_SIZE    = Y_SIZE_DEF,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 in_stream_aclk,
  input  logic                 periph_reset,
  input  logic [31:0]          in_stream_tdata,
  input  logic [3:0]           in_stream_tkeep,
  input  logic                 in_stream_tlast,
  input  logic                 in_stream_tuser,
  input  logic                 in_stream_tvalid,
  output logic                 in_stream_tready,
  output logic [7:0]           pix_r,
  output logic [7:0]           pix_g,
  output logic [7:0]           pix_b,
  output logic [XW-1:0]        pix_x,
  output logic [YW-1:0]        pix_y,
  output logic                 pix_sof,
  output logic                 pix_eol,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] err_count
);
  phase_t        phase, ph;
  logic [15:0]   res;
  logic          pend_valid, pend_eol;
  rgb_t          pend_pix, p0, p1;
  logic [XW-1:0] pend_x, px, bx, bx1;
  logic [YW-1:0] pend_y, py, by;
  logic          bsof, beol, acc, free, done, sof_exp, last_exp, early, err;
  logic [7:0]    b0, b1, b2, b3;
  assign {b3, b2, b1, b0} = in_stream_tdata;
  assign free             = !pix_valid || pix_ready;
  assign in_stream_tready = !periph_reset && !pend_valid && free;
  assign acc              = in_stream_tvalid && in_stream_tready;
  assign done             = pix_valid && pix_ready && pix_x == XW'(X_SIZE - 1) && pix_y == YW'(Y_SIZE - 1);
  assign sof_exp          = phase == PH0 && px == '0 && py == '0;
  assign ph               = in_stream_tuser ? PH0 : phase;
  assign last_exp         = ph == PH2 && bx == XW'(X_SIZE - 2);
  assign early            = in_stream_tlast && !last_exp;
  assign err              = in_stream_tuser != sof_exp || in_stream_tlast != last_exp || in_stream_tkeep != 4'hF;
  assign bx1              = bx + 1'b1;
  assign p1               = lanes_to_rgb(b1, b2, b3);
  always_comb
    p0 = ph == PH0 ? lanes_to_rgb(b0, b1, b2) :
         ph == PH1 ? lanes_to_rgb(res[7:0], b0, b1) : lanes_to_rgb(res[7:0], res[15:8], b0);
  pixel_pos_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_pos (
    .clk(in_stream_aclk),
    .rst(periph_reset),
    .en (acc),
    .frm(in_stream_tuser),
    .nl (early),
    .adv(ph == PH2 ? 2'd2 : 2'd1),
    .x  (px),
    .y  (py),
    .bx (bx),
    .by (by),
    .sof(bsof),
    .eol(beol)
  );
  always_ff @(posedge in_stream_aclk) begin
    if (periph_reset) begin
      phase       <= PH0;
      res         <= '0;
      pend_valid  <= 1'b0;
      pend_pix    <= '0;
      pend_x      <= '0;
      pend_y      <= '0;
      pend_eol    <= 1'b0;
      {pix_r, pix_g, pix_b} <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      pix_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      frame_done <= done;
      if (done && frame_count != '1) frame_count <= frame_count + 1'b1;
      if (acc && err && err_count != '1) err_count <= err_count + 1'b1;
      if (acc) begin
        phase      <= (early || ph == PH2) ? PH0 : phase_t'(ph + 2'd1);
        res        <= ph == PH1 ? in_stream_tdata[31:16] : {8'h00, b3};
        {pix_r, pix_g, pix_b} <= p0;
        pix_x      <= bx;
        pix_y      <= by;
        pix_sof    <= bsof;
        pix_eol    <= beol;
        pix_valid  <= 1'b1;
        pend_valid <= ph == PH2;
        pend_pix   <= p1;
        pend_x     <= bx1;
        pend_y     <= by;
        pend_eol   <= bx1 == XW'(X_SIZE - 1);
      end else if (pend_valid && free) begin
        {pix_r, pix_g, pix_b} <= pend_pix;
        pix_x      <= pend_x;
        pix_y      <= pend_y;
        pix_sof    <= 1'b0;
        pix_eol    <= pend_eol;
        pix_valid  <= 1'b1;
        pend_valid <= 1'b0;
      end else if (pix_ready) begin
        pix_valid  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pixel_stream_unpacker.sv
// tb_pixel_stream_unpacker: scoreboard bench for the packed-RGB stream unpacker on a reduced 160x8 frame
module tb_pixel_stream_unpacker;
  localparam int XS  = 160;
  localparam int YS  = 8;
  localparam int WPL = XS * 3 / 4;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } beat_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] x;
    logic [8:0] y;
    logic       sof;
    logic       eol;
  } px_t;
  logic        in_stream_aclk = 1'b0;
  logic        periph_reset = 1'b1;
  logic [31:0] in_stream_tdata = '0;
  logic [3:0]  in_stream_tkeep = 4'hF;
  logic        in_stream_tlast = 1'b0;
  logic        in_stream_tuser = 1'b0;
  logic        in_stream_tvalid = 1'b0;
  logic        in_stream_tready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_sof, pix_eol, pix_valid, frame_done;
  logic        pix_ready = 1'b1;
  logic [15:0] frame_count, err_count;
  beat_t       bq[$];
  px_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  always #5 in_stream_aclk = ~in_stream_aclk;
  pixel_stream_unpacker #(.X_SIZE(XS), .Y_SIZE(YS), .CNT_WIDTH(16)) dut (
    .in_stream_aclk  (in_stream_aclk),
    .periph_reset    (periph_reset),
    .in_stream_tdata (in_stream_tdata),
    .in_stream_tkeep (in_stream_tkeep),
    .in_stream_tlast (in_stream_tlast),
    .in_stream_tuser (in_stream_tuser),
    .in_stream_tvalid(in_stream_tvalid),
    .in_stream_tready(in_stream_tready),
    .pix_r           (pix_r),
    .pix_g           (pix_g),
    .pix_b           (pix_b),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_sof         (pix_sof),
    .pix_eol         (pix_eol),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .frame_done      (frame_done),
    .frame_count     (frame_count),
    .err_count       (err_count)
  );
  always @(negedge in_stream_aclk)
    if (periph_reset) fd_cnt <= 0;
    else if (frame_done) fd_cnt <= fd_cnt + 1;
  function automatic px_t mkpx(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input int x, input int y);
    return {r, g, b, 10'(x), 9'(y), x == 0 && y == 0, x == XS - 1};
  endfunction
  task automatic do_reset();
    periph_reset = 1'b1;
    in_stream_tvalid = 1'b0;
    in_stream_tuser = 1'b0;
    in_stream_tlast = 1'b0;
    in_stream_tkeep = 4'hF;
    pix_ready = 1'b1;
    bq.delete();
    exp_q.delete();
    repeat (2) @(posedge in_stream_aclk);
    #1 periph_reset = 1'b0;
  endtask
  task automatic add_line(input int y, input int n, input int last_at, input bit user, input int bad_keep);
    logic [7:0] lb [XS*3];
    beat_t b;
    for (int i = 0; i < XS * 3; i++) lb[i] = 8'($urandom);
    for (int w = 0; w < n; w++) begin
      b.d = {lb[4*w+3], lb[4*w+2], lb[4*w+1], lb[4*w]};
      b.k = w == bad_keep ? 4'h7 : 4'hF;
      b.l = w == last_at;
      b.u = user && w == 0;
      bq.push_back(b);
    end
    for (int i = 0; i < n * 4 / 3; i++) exp_q.push_back(mkpx(lb[3*i+2], lb[3*i+1], lb[3*i], i, y));
  endtask
  task automatic drive_beats();
    beat_t b;
    int t;
    while (bq.size() > 0) begin
      b = bq.pop_front();
      {in_stream_tdata, in_stream_tkeep, in_stream_tlast, in_stream_tuser} = b;
      in_stream_tvalid = 1'b1;
      t = 0;
      @(negedge in_stream_aclk);
      while (!in_stream_tready && t < 1000) begin
        t++;
        @(negedge in_stream_aclk);
      end
      if (!in_stream_tready) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout: tready stayed %b, required 1", in_stream_tready);
        bq.delete();
      end
      @(posedge in_stream_aclk);
      #1;
    end
    in_stream_tvalid = 1'b0;
    in_stream_tuser = 1'b0;
    in_stream_tlast = 1'b0;
  endtask
  task automatic consume(input int n, input bit stall);
    int got, t;
    px_t o, e;
    got = 0;
    t = 0;
    while (got < n && t < 20000) begin
      @(posedge in_stream_aclk);
      #1 pix_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge in_stream_aclk);
      t++;
      if (pix_valid && pix_ready) begin
        o = {pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel_extra: got %h, required no pixel", o);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            errors++;
            $display("FAIL pixel_%0d: got rgb=%h x=%0d y=%0d sof=%b eol=%b, required rgb=%h x=%0d y=%0d sof=%b eol=%b",
                     got, o[44:21], o.x, o.y, o.sof, o.eol, e[44:21], e.x, e.y, e.sof, e.eol);
          end
        end
        got++;
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL consume_timeout: got %0d pixels, required %0d", got, n);
    end
  endtask
  task automatic run(input int n, input bit stall);
    fork
      drive_beats();
      consume(n, stall);
    join
    @(posedge in_stream_aclk);
    #1 pix_ready = 1'b1;
  endtask
  task automatic test_reset();
    periph_reset = 1'b1;
    in_stream_tvalid = 1'b1;
    repeat (2) @(posedge in_stream_aclk);
    @(negedge in_stream_aclk);
    checks++;
    if (in_stream_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b, required 0", in_stream_tready); end
    checks++;
    if ({pix_valid, frame_done} !== 2'b00) begin errors++; $display("FAIL reset_valid: got valid=%b done=%b, required 0 0", pix_valid, frame_done); end
    checks++;
    if ({pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol} !== '0) begin
      errors++;
      $display("FAIL reset_pix: got rgb=%h x=%0d y=%0d, required 0", {pix_r, pix_g, pix_b}, pix_x, pix_y);
    end
    checks++;
    if ({frame_count, err_count} !== '0) begin errors++; $display("FAIL reset_counts: got frames=%0d errs=%0d, required 0 0", frame_count, err_count); end
    @(posedge in_stream_aclk);
    #1 periph_reset = 1'b0;
    in_stream_tvalid = 1'b0;
    @(negedge in_stream_aclk);
    checks++;
    if (in_stream_tready !== 1'b1) begin errors++; $display("FAIL idle_tready: got %b, required 1", in_stream_tready); end
    @(posedge in_stream_aclk);
    #1;
  endtask
  task automatic test_single();
    do_reset();
    in_stream_tdata = 32'h66112233;
    in_stream_tuser = 1'b1;
    in_stream_tvalid = 1'b1;
    @(negedge in_stream_aclk);
    checks++;
    if (in_stream_tready !== 1'b1) begin errors++; $display("FAIL single_tready: got %b, required 1", in_stream_tready); end
    @(posedge in_stream_aclk);
    #1 in_stream_tvalid = 1'b0;
    in_stream_tuser = 1'b0;
    @(negedge in_stream_aclk);
    checks++;
    if (pix_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got valid=%b, required 1", pix_valid); end
    checks++;
    if ({pix_r, pix_g, pix_b} !== 24'h112233) begin errors++; $display("FAIL single_rgb: got %h, required 112233", {pix_r, pix_g, pix_b}); end
    checks++;
    if ({pix_x, pix_y, pix_sof, pix_eol} !== {10'd0, 9'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_pos: got x=%0d y=%0d sof=%b eol=%b, required 0 0 1 0", pix_x, pix_y, pix_sof, pix_eol);
    end
    checks++;
    if (err_count !== 16'd0) begin errors++; $display("FAIL single_err: got %0d, required 0", err_count); end
    @(posedge in_stream_aclk);
    #1;
  endtask
  task automatic test_back_to_back();
    logic [31:0] w [3];
    w[0] = 32'h66112233;
    w[1] = 32'h99AA4455;
    w[2] = 32'hCCDDEEFF;
    do_reset();
    exp_q.push_back(mkpx(8'h11, 8'h22, 8'h33, 0, 0));
    exp_q.push_back(mkpx(8'h44, 8'h55, 8'h66, 1, 0));
    exp_q.push_back(mkpx(8'hFF, 8'h99, 8'hAA, 2, 0));
    exp_q.push_back(mkpx(8'hCC, 8'hDD, 8'hEE, 3, 0));
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          in_stream_tdata = w[i];
          in_stream_tuser = i == 0;
          in_stream_tvalid = 1'b1;
          @(negedge in_stream_aclk);
          checks++;
          if (in_stream_tready !== 1'b1) begin errors++; $display("FAIL b2b_tready_w%0d: got %b, required 1", i, in_stream_tready); end
          @(posedge in_stream_aclk);
          #1;
        end
        in_stream_tvalid = 1'b0;
        in_stream_tuser = 1'b0;
        @(negedge in_stream_aclk);
        checks++;
        if (in_stream_tready !== 1'b0) begin errors++; $display("FAIL b2b_tready_gap: got %b, required 0", in_stream_tready); end
        @(negedge in_stream_aclk);
        checks++;
        if (in_stream_tready !== 1'b1) begin errors++; $display("FAIL b2b_tready_back: got %b, required 1", in_stream_tready); end
      end
      consume(4, 1'b0);
    join
    @(posedge in_stream_aclk);
    #1;
  endtask
  task automatic test_full_frame();
    do_reset();
    for (int y = 0; y < YS; y++) add_line(y, WPL, WPL - 1, y == 0, -1);
    run(XS * YS, 1'b1);
    @(negedge in_stream_aclk);
    @(negedge in_stream_aclk);
    checks++;
    if (fd_cnt !== 1) begin errors++; $display("FAIL frame_done_pulses: got %0d, required 1", fd_cnt); end
    checks++;
    if (frame_count !== 16'd1) begin errors++; $display("FAIL frame_count: got %0d, required 1", frame_count); end
    checks++;
    if (err_count !== 16'd0) begin errors++; $display("FAIL frame_err: got %0d, required 0", err_count); end
    @(posedge in_stream_aclk);
    #1;
  endtask
  task automatic test_early_tlast();
    do_reset();
    add_line(0, 101, 100, 1'b1, -1);
    add_line(1, WPL, WPL - 1, 1'b0, -1);
    run(134 + XS, 1'b0);
    @(negedge in_stream_aclk);
    checks++;
    if (err_count !== 16'd1) begin errors++; $display("FAIL early_tlast_err: got %0d, required 1", err_count); end
    @(posedge in_stream_aclk);
    #1;
  endtask
  task automatic test_tuser_resync();
    do_reset();
    add_line(0, 4, -1, 1'b1, -1);
    add_line(0, WPL, WPL - 1, 1'b1, -1);
    run(5 + XS, 1'b1);
    @(negedge in_stream_aclk);
    checks++;
    if (err_count !== 16'd1) begin errors++; $display("FAIL tuser_resync_err: got %0d, required 1", err_count); end
    @(posedge in_stream_aclk);
    #1;
  endtask
  task automatic test_keep_and_reset();
    do_reset();
    add_line(0, 10, -1, 1'b1, 5);
    run(13, 1'b0);
    pix_ready = 1'b0;
    in_stream_tdata = 32'hDEADBEEF;
    in_stream_tvalid = 1'b1;
    @(negedge in_stream_aclk);
    checks++;
    if (err_count !== 16'd1) begin errors++; $display("FAIL keep_err: got %0d, required 1", err_count); end
    checks++;
    if (in_stream_tready !== 1'b1) begin errors++; $display("FAIL hold_tready: got %b, required 1", in_stream_tready); end
    @(posedge in_stream_aclk);
    #1 periph_reset = 1'b1;
    @(negedge in_stream_aclk);
    checks++;
    if (in_stream_tready !== 1'b0) begin errors++; $display("FAIL midreset_tready: got %b, required 0", in_stream_tready); end
    checks++;
    if (pix_valid !== 1'b1) begin errors++; $display("FAIL midreset_held: got valid=%b, required 1", pix_valid); end
    @(posedge in_stream_aclk);
    #1 periph_reset = 1'b0;
    in_stream_tvalid = 1'b0;
    pix_ready = 1'b1;
    @(negedge in_stream_aclk);
    checks++;
    if ({pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol, frame_done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%b rgb=%h x=%0d y=%0d, required all 0", pix_valid, {pix_r, pix_g, pix_b}, pix_x, pix_y);
    end
    checks++;
    if (err_count !== 16'd0) begin errors++; $display("FAIL midreset_err: got %0d, required 0", err_count); end
    @(posedge in_stream_aclk);
    #1;
    add_line(0, WPL, WPL - 1, 1'b1, -1);
    run(XS, 1'b0);
    @(negedge in_stream_aclk);
    checks++;
    if (err_count !== 16'd0) begin errors++; $display("FAIL post_reset_err: got %0d, required 0", err_count); end
    @(posedge in_stream_aclk);
    #1;
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_frame();
    test_early_tlast();
    test_tuser_resync();
    test_keep_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
